// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nines' complement of one BCD digit (9 - d); invalid digits stay invalid.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(BCD_MAX) - d;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle of bcd_serial_adder; the sub port exists only when BCD_SUB_EN is defined.
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
) ();
  import bcd_pkg::*;

  localparam int unsigned W = DIGIT_W * DIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
`ifdef BCD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  sum, cout, busy, done, err
  );

  modport slave (
`ifdef BCD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output sum, cout, busy, done, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and invalid-digit flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               inv
);

  logic [DIGIT_W:0] bin;

  always_comb begin
    bin = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(ci);
    inv = (a > DIGIT_W'(BCD_MAX)) || (b > DIGIT_W'(BCD_MAX));
    s   = bin[DIGIT_W-1:0];
    co  = 1'b0;
    // Binary sums above 9 wrap into the next decade by adding 6.
    if (bin > (DIGIT_W+1)'(BCD_MAX)) begin
      s  = DIGIT_W'(bin + (DIGIT_W+1)'(BCD_CORR));
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder, one digit per clock LSD first; BCD_SUB_EN adds tens'-complement subtract.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned W     = DIGIT_W * DIGITS;

  state_t             state;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       sum_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [DIGIT_W-1:0] b_raw;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] digit;
  logic               digit_co;
  logic               digit_inv;
  logic               digit_err;
  logic               cin_eff;
  logic [W-1:0]       sum_next;
  logic               last;
  logic               accept;

`ifdef BCD_SUB_EN
  logic               sub_q;

  // Subtract adds the nines' complement of B plus a forced carry-in; err looks at the raw B digit.
  always_comb begin
    b_raw     = b_sh[DIGIT_W-1:0];
    b_dig     = sub_q ? nines_comp(b_raw) : b_raw;
    digit_err = digit_inv || (b_raw > DIGIT_W'(BCD_MAX));
    cin_eff   = bus.cin || bus.sub;
  end
`else
  always_comb begin
    b_raw     = b_sh[DIGIT_W-1:0];
    b_dig     = b_raw;
    digit_err = digit_inv;
    cin_eff   = bus.cin;
  end
`endif

  bcd_digit_add u_digit (
    .a   (a_sh[DIGIT_W-1:0]),
    .b   (b_dig),
    .ci  (carry),
    .s   (digit),
    .co  (digit_co),
    .inv (digit_inv)
  );

  // New digit enters at the MSD end so the result is aligned after DIGITS shifts.
  always_comb begin
    sum_next = (sum_q >> DIGIT_W) | (W'(digit) << (W - DIGIT_W));
    last     = (cnt == CNT_W'(DIGITS - 1));
    accept   = bus.start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= RUN;
            busy_q <= 1'b1;
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= cin_eff;
            cnt    <= '0;
            err_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q  <= bus.sub;
`endif
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          a_sh  <= a_sh >> DIGIT_W;
          b_sh  <= b_sh >> DIGIT_W;
          carry <= digit_co;
          cnt   <= cnt + CNT_W'(1);
          err_q <= err_q || digit_err;
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cout_q <= digit_co;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed, table-driven bench for bcd_serial_adder at DIGITS=2, 4 and 1.
module tb_bcd_serial_adder;
  import bcd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst4, rst1;

  bcd_serial_adder_if #(.DIGITS(2)) f2 ();
  bcd_serial_adder_if #(.DIGITS(4)) f4 ();
  bcd_serial_adder_if #(.DIGITS(1)) f1 ();

  bcd_serial_adder #(.DIGITS(2)) u2 (.clk(clk), .rst(rst2), .bus(f2.slave));
  bcd_serial_adder #(.DIGITS(4)) u4 (.clk(clk), .rst(rst4), .bus(f4.slave));
  bcd_serial_adder #(.DIGITS(1)) u1 (.clk(clk), .rst(rst1), .bus(f1.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       chk_sum;
    logic [7:0] sum;
    logic       cout;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic start2(input logic [7:0] a, input logic [7:0] b, input logic cin);
    f2.a = a; f2.b = b; f2.cin = cin; f2.start = 1'b1;
    @(posedge clk); #1;
    f2.start = 1'b0;
  endtask

  // Counts busy cycles until done, bounded so a stuck FSM cannot hang the run.
  task automatic wait2(output int bc, output bit seen);
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (f2.done) begin seen = 1'b1; break; end
      if (f2.busy) bc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  bc;
    bit  seen;
    int  ndone;

    rst2 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
    f2.start = 1'b0; f2.a = '0; f2.b = '0; f2.cin = 1'b0;
    f4.start = 1'b0; f4.a = '0; f4.b = '0; f4.cin = 1'b0;
    f1.start = 1'b0; f1.a = '0; f1.b = '0; f1.cin = 1'b0;
`ifdef BCD_SUB_EN
    f2.sub = 1'b0; f4.sub = 1'b0; f1.sub = 1'b0;
`endif

    //          a      b      cin  sub  chk  sum    cout err
    vecs.push_back('{8'h62, 8'h98, 1'b0, 1'b0, 1'b1, 8'h60, 1'b1, 1'b0});
    vecs.push_back('{8'h99, 8'h99, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0});
    vecs.push_back('{8'h17, 8'h24, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'h50, 8'h50, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h1A, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 8'h16, 1'b0, 1'b0, 1'b1, 8'h17, 1'b0, 1'b0});
    vecs.push_back('{8'hB0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
`ifdef BCD_SUB_EN
    vecs.push_back('{8'h62, 8'h17, 1'b0, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0});
    vecs.push_back('{8'h17, 8'h24, 1'b0, 1'b1, 1'b1, 8'h93, 1'b0, 1'b0});
    vecs.push_back('{8'h50, 8'h50, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h30, 8'h0C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst2_sum",  32'(f2.sum),  32'h0);
    chk("rst2_cout", 32'(f2.cout), 32'h0);
    chk("rst2_busy", 32'(f2.busy), 32'h0);
    chk("rst2_done", 32'(f2.done), 32'h0);
    chk("rst2_err",  32'(f2.err),  32'h0);
    chk("rst4_sum",  32'(f4.sum),  32'h0);
    rst2 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;

    // Table: one operation each, then confirm the DONE->IDLE return and held result.
    for (int i = 0; i < vecs.size(); i++) begin
`ifdef BCD_SUB_EN
      f2.sub = vecs[i].sub;
`endif
      start2(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait2(bc, seen);
      chk($sformatf("v%0d_done", i), 32'(seen), 32'h1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd2);
      if (vecs[i].chk_sum) begin
        chk($sformatf("v%0d_sum", i),  32'(f2.sum),  32'(vecs[i].sum));
        chk($sformatf("v%0d_cout", i), 32'(f2.cout), 32'(vecs[i].cout));
      end
      chk($sformatf("v%0d_err", i), 32'(f2.err), 32'(vecs[i].err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(f2.done), 32'h0);
      chk($sformatf("v%0d_idle", i), 32'(f2.busy), 32'h0);
      if (vecs[i].chk_sum)
        chk($sformatf("v%0d_sum_hold", i), 32'(f2.sum), 32'(vecs[i].sum));
    end
`ifdef BCD_SUB_EN
    f2.sub = 1'b0;
`endif

    // Back-to-back: new start accepted in the DONE cycle.
    start2(8'h99, 8'h99, 1'b1);
    wait2(bc, seen);
    chk("b2b_first_done", 32'(seen), 32'h1);
    chk("b2b_first_sum",  32'(f2.sum), 32'h99);
    start2(8'h17, 8'h24, 1'b1);
    chk("b2b_no_gap_busy", 32'(f2.busy), 32'h1);
    chk("b2b_no_gap_done", 32'(f2.done), 32'h0);
    wait2(bc, seen);
    chk("b2b_second_done",   32'(seen), 32'h1);
    chk("b2b_second_cycles", 32'(bc), 32'd2);
    chk("b2b_second_sum",    32'(f2.sum), 32'h42);
    chk("b2b_second_cout",   32'(f2.cout), 32'h0);

    // DIGITS=4 with a start pulse mid-RUN that must be ignored.
    f4.a = 16'h9999; f4.b = 16'h0001; f4.cin = 1'b0; f4.start = 1'b1;
    @(posedge clk); #1;
    f4.start = 1'b0;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (f4.done) begin seen = 1'b1; break; end
      if (f4.busy) bc++;
      if (i == 1) begin
        f4.a = 16'h1234; f4.b = 16'h4321; f4.start = 1'b1;
      end else begin
        f4.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    f4.start = 1'b0;
    chk("d4_done",        32'(seen), 32'h1);
    chk("d4_busy_cycles", 32'(bc), 32'd4);
    chk("d4_sum",         32'(f4.sum), 32'h0000);
    chk("d4_cout",        32'(f4.cout), 32'h1);
    chk("d4_err",         32'(f4.err), 32'h0);
    @(posedge clk); #1;
    chk("d4_no_relaunch", 32'(f4.busy), 32'h0);
    chk("d4_sum_hold",    32'(f4.sum), 32'h0000);

    // DIGITS=1: RUN lasts a single cycle.
    f1.a = 4'h7; f1.b = 4'h5; f1.cin = 1'b0; f1.start = 1'b1;
    @(posedge clk); #1;
    f1.start = 1'b0;
    chk("d1_busy", 32'(f1.busy), 32'h1);
    @(posedge clk); #1;
    chk("d1_done", 32'(f1.done), 32'h1);
    chk("d1_sum",  32'(f1.sum),  32'h2);
    chk("d1_cout", 32'(f1.cout), 32'h1);
    f1.a = 4'h4; f1.b = 4'h4; f1.cin = 1'b1; f1.start = 1'b1;
    @(posedge clk); #1;
    f1.start = 1'b0;
    @(posedge clk); #1;
    chk("d1b_done", 32'(f1.done), 32'h1);
    chk("d1b_sum",  32'(f1.sum),  32'h9);
    chk("d1b_cout", 32'(f1.cout), 32'h0);

    // Reset during the second RUN cycle aborts the operation.
    start2(8'h62, 8'h98, 1'b0);
    @(posedge clk); #1;
    chk("abort_in_run", 32'(f2.busy), 32'h1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("abort_sum",  32'(f2.sum),  32'h0);
    chk("abort_cout", 32'(f2.cout), 32'h0);
    chk("abort_busy", 32'(f2.busy), 32'h0);
    chk("abort_done", 32'(f2.done), 32'h0);
    chk("abort_err",  32'(f2.err),  32'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (f2.done || f2.busy) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
